qr_ser_gearbox: RTL

//  Parametrised parallel-to-quarter-rate gearbox feeding the TX 4:1 serializer mux.

---
 rtl/qr_ser_gearbox.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/qr_ser_gearbox.sv
// Parallel-to-quarter-rate gearbox: buffers wide words in a small FIFO and
// hands one narrow slice per clock to the TX serializer mux. Besides the data
// path it can source PRBS7, a fixed per-clock pattern, or idle zeros.
module qr_ser_gearbox #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [OUT_WIDTH-1:0] pattern,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 underflow,
  input  logic                 underflow_clr
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(RATIO + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  RATIO_C   = SC_W'(RATIO);
  localparam logic [6:0]       LFSR_SEED = 7'h7F;

  // Reject parameter sets the slicing and pointer-wrap logic cannot handle.
  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
    $error("qr_ser_gearbox: IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("qr_ser_gearbox: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    MODE_DATA    = 2'd0,
    MODE_PRBS    = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_IDLE    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  mode_e                mode_sel;
  state_e               state, state_nxt;
  logic [IN_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [SC_W-1:0]      slice_cnt, slice_cnt_nxt;
  logic [IN_WIDTH-1:0]  word_reg, word_nxt;
  logic [IN_WIDTH-1:0]  head;
  logic [OUT_WIDTH-1:0] out_data_nxt;
  logic                 out_valid_nxt;
  logic [6:0]           lfsr, lfsr_nxt, lfsr_v;
  logic [OUT_WIDTH-1:0] prbs_bits;
  logic                 prbs_active;
  logic                 do_push, pop, flush, uf_set;

  // Slice k of a word in transmit order.
  function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [IN_WIDTH-1:0] w, input int idx);
    if (MSB_FIRST) return w[IN_WIDTH-1-idx*OUT_WIDTH -: OUT_WIDTH];
    else           return w[idx*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  assign mode_sel = mode_e'(mode);
  assign head     = fifo_mem[rd_ptr];
  assign in_ready = rstb && (mode_sel == MODE_DATA) && (count < DEPTH_C);
  assign do_push  = in_valid && in_ready;

  // Next-state and next-output decode for the slicer FSM and the test sources.
  always_comb begin
    state_nxt     = state;
    slice_cnt_nxt = slice_cnt;
    word_nxt      = word_reg;
    out_data_nxt  = '0;
    out_valid_nxt = 1'b0;
    lfsr_nxt      = lfsr;
    lfsr_v        = LFSR_SEED;
    prbs_bits     = '0;
    pop           = 1'b0;
    flush         = 1'b0;
    uf_set        = 1'b0;
    case (mode_sel)
      MODE_DATA: begin
        case (state)
          ST_IDLE: begin
            if (count != '0) begin
              pop           = 1'b1;
              word_nxt      = head;
              out_data_nxt  = slice_of(head, 0);
              out_valid_nxt = 1'b1;
              slice_cnt_nxt = SC_W'(1);
              state_nxt     = ST_RUN;
            end
          end
          ST_RUN: begin
            if (slice_cnt < RATIO_C) begin
              out_data_nxt  = slice_of(word_reg, int'(slice_cnt));
              out_valid_nxt = 1'b1;
              slice_cnt_nxt = slice_cnt + SC_W'(1);
            end else if (count != '0) begin
              pop           = 1'b1;
              word_nxt      = head;
              out_data_nxt  = slice_of(head, 0);
              out_valid_nxt = 1'b1;
              slice_cnt_nxt = SC_W'(1);
            end else begin
              uf_set        = 1'b1;
              slice_cnt_nxt = '0;
              state_nxt     = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
      MODE_PRBS: begin
        flush         = 1'b1;
        state_nxt     = ST_IDLE;
        slice_cnt_nxt = '0;
        lfsr_v        = prbs_active ? lfsr : LFSR_SEED;
        for (int i = 0; i < OUT_WIDTH; i++) begin
          prbs_bits[OUT_WIDTH-1-i] = lfsr_v[6];
          lfsr_v = {lfsr_v[5:0], lfsr_v[6] ^ lfsr_v[5]};
        end
        lfsr_nxt      = lfsr_v;
        out_data_nxt  = prbs_bits;
        out_valid_nxt = 1'b1;
      end
      MODE_PATTERN: begin
        flush         = 1'b1;
        state_nxt     = ST_IDLE;
        slice_cnt_nxt = '0;
        out_data_nxt  = pattern;
        out_valid_nxt = 1'b1;
      end
      default: begin
        flush         = 1'b1;
        state_nxt     = ST_IDLE;
        slice_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, current word, output slice and PRBS generator registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      slice_cnt   <= '0;
      word_reg    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      lfsr        <= LFSR_SEED;
      prbs_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      slice_cnt   <= slice_cnt_nxt;
      word_reg    <= word_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      lfsr        <= lfsr_nxt;
      prbs_active <= (mode_sel == MODE_PRBS);
    end
  end

  // FIFO occupancy and pointers; leaving DATA mode discards everything buffered.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !pop)      count <= count + CNT_W'(1);
      else if (!do_push && pop) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= in_data;
  end

  // Sticky underflow flag; a clear in the same cycle as a new underflow wins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)              underflow <= 1'b0;
    else if (underflow_clr) underflow <= 1'b0;
    else if (uf_set)        underflow <= 1'b1;
  end

endmodule
